popcnt_stream: RTL
==================

# popcnt_stream

- Streaming population counter for frames of 1..BEATS beats of DATA_W bits each, with valid/ready on both sides.
- Each beat's ones are counted in a pipelined adder tree and accumulated per frame. One result is emitted per frame: ones count, beat count, and a short-frame flag.
- Sits between a byte/word source and control logic that needs per-frame bit statistics.
- Supersedes the fixed 8-bit, free-running static counter.

## Interface
- DATA_W, 32, beat width in bits; multiple of 8, ≥ 8
- BEATS, 8, maximum beats per frame; ≥ 2
- CNT_W, $clog2(DATA_W*BEATS+1), width of the ones count; must hold DATA_W*BEATS exactly
- BCNT_W, $clog2(BEATS+1), width of the beat count
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  DATA_W  beat data
- s_last  in  1  closes the frame early on this beat
- m_valid  out  1  frame result valid
- m_ready  in  1  result consumed when m_valid && m_ready
- m_ones  out  CNT_W  total ones in the frame
- m_beats  out  BCNT_W  beats in the frame, 1..BEATS
- m_short  out  1  frame closed by s_last before BEATS beats

## Operation
- Global advance enable: en = !m_valid || m_ready. s_ready = en. When en=0, every stage holds.
- Input stage:
  - Beat counter bcnt counts accepted beats within the frame.
  - A beat is final if s_last=1 or bcnt==BEATS-1. On a final beat, bcnt returns to 0; otherwise it increments.
  - s_last on beat BEATS is a normal final beat: m_short=0.
- P1: registers the per-byte popcounts (4-bit each), valid, final flag and beat number.
- P2: registers the beat sum. Width is $clog2(DATA_W+1).
- P3 accumulator:
  - Non-final beat: acc += beat sum.
  - Final beat: load m_ones = acc + beat sum, m_beats = beat number + 1, m_short = (beat number + 1 < BEATS). Set m_valid = 1 and clear acc to 0.
- All sums are unsigned and zero-extended to CNT_W. Overflow cannot occur by construction of CNT_W.
- m_valid && m_ready with a new final beat in P2 in the same cycle: the new result loads, m_valid stays 1.
- m_valid && m_ready with no final beat in P2: m_valid clears next cycle.
- Outputs stay stable while m_valid && !m_ready.

## Timing
- Reset values: s_ready=1, m_valid=0, m_ones=0, m_beats=0, m_short=0. Accumulator, bcnt and all pipe valids are 0.
- Latency: final beat accepted in cycle t gives m_valid=1 in cycle t+3, assuming no stall.
- Throughput: 1 beat/cycle while m_ready=1. Back-to-back frames need no bubble.
- Stall: while m_valid && !m_ready, s_ready=0 and no beat is lost or duplicated.
- Reset mid-frame: the partial frame, in-flight beats and any pending result are discarded. The next accepted beat starts a new frame.

## Configuration
- POPCNT_THRESH_EN defined:
  - Adds input thresh (CNT_W, sampled when the result loads) and output m_over (1 bit, reset 0).
  - m_over = (m_ones ≥ thresh). It is registered with m_ones and valid with m_valid.
- Not defined: neither port exists and no comparator is built.

## Structure
- Package popcnt_pkg:
  - function popcnt8 (8-bit input to 4-bit count)
  - localparam helper for CNT_W
  - typedef of the per-pipe-stage struct {valid, final, beat number}
- Sub-module popcnt_tree:
  - Parametrised by DATA_W; P1/P2 registered byte-count tree with enable.
  - Instantiated once; the accumulator and handshake stay in popcnt_stream.

## Test plan
- DATA_W=32, BEATS=8: 8 beats of 0xFFFFFFFF, m_ready=1 → m_ones=256, m_beats=8, m_short=0, m_valid 3 cycles after the last beat.
- 3 beats of 0x0000000F, s_last on beat 3 → m_ones=12, m_beats=3, m_short=1.
- Two back-to-back frames of 0x80000001 ×8, m_ready held 0 for 10 cycles:
  - s_ready=0 from the cycle after the first m_valid; first result 16 held stable.
  - After release, second result 16 arrives; total accepted beats = 16.
- Assert rst_n=0 after 4 beats of 0xFFFFFFFF, then one full frame of 0x01010101 → single result m_ones=32, m_beats=8.
- POPCNT_THRESH_EN, thresh=100:
  - frame 0xAAAAAAAA ×8 → m_ones=128, m_over=1
  - frame 0x00000001 ×8 → m_ones=8, m_over=0
- DATA_W=8, BEATS=32, all beats 0xFF → m_ones=256 with CNT_W=9, no truncation.

Source files
------------

// File: rtl/popcnt_pkg.sv
// rtl/popcnt_pkg.sv - shared types and helpers for popcnt_stream
package popcnt_pkg;

  // Beat-number field width carried through the pipe; covers BEATS up to 65535.
  localparam int BNUM_W = 16;

  // Per-pipe-stage tag travelling alongside the data.
  typedef struct packed {
    logic              valid;
    logic              fin;
    logic [BNUM_W-1:0] bnum;
  } stage_t;

  // Number of ones in one byte.
  function automatic logic [3:0] popcnt8(input logic [7:0] b);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, b[i]};
    end
    return c;
  endfunction

  // Width of the per-frame ones count; must hold data_w*beats exactly.
  function automatic int cnt_width(input int data_w, input int beats);
    return $clog2(data_w * beats + 1);
  endfunction

endpackage

// File: rtl/popcnt_tree.sv
// rtl/popcnt_tree.sv - two-stage registered byte-popcount adder tree with enable
module popcnt_tree
  import popcnt_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int SUM_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  input  stage_t            tag_in,
  output stage_t            tag_out,
  output logic [SUM_W-1:0]  sum
);

  localparam int NB = DATA_W / 8;

  logic [3:0]       p1_cnt [NB];
  stage_t           p1_tag;
  logic [SUM_W-1:0] byte_sum;

  // P1: per-byte popcounts and the beat tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) begin
        p1_cnt[i] <= '0;
      end
      p1_tag <= '0;
    end else if (en) begin
      for (int i = 0; i < NB; i++) begin
        p1_cnt[i] <= popcnt8(data[8*i +: 8]);
      end
      p1_tag <= tag_in;
    end
  end

  // Reduce the registered byte counts to one beat sum
  always_comb begin
    byte_sum = '0;
    for (int i = 0; i < NB; i++) begin
      byte_sum = byte_sum + SUM_W'(p1_cnt[i]);
    end
  end

  // P2: registered beat sum and tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= '0;
      tag_out <= '0;
    end else if (en) begin
      sum     <= byte_sum;
      tag_out <= p1_tag;
    end
  end

endmodule

// File: rtl/popcnt_stream.sv
// rtl/popcnt_stream.sv - per-frame streaming popcount; optional POPCNT_THRESH_EN threshold flag
module popcnt_stream
  import popcnt_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BEATS  = 8,
  parameter int CNT_W  = cnt_width(DATA_W, BEATS),
  parameter int BCNT_W = $clog2(BEATS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  m_ones,
  output logic [BCNT_W-1:0] m_beats,
  output logic              m_short
`ifdef POPCNT_THRESH_EN
  ,
  input  logic [CNT_W-1:0]  thresh,
  output logic              m_over
`endif
);

  localparam int SUM_W = $clog2(DATA_W + 1);

  logic              en;
  logic              accept;
  logic              is_final;
  logic [BCNT_W-1:0] bcnt;
  stage_t            in_tag;
  stage_t            p2_tag;
  logic [SUM_W-1:0]  p2_sum;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  total;
  logic [BCNT_W-1:0] nbeats;

  // The whole pipe advances only when the result register can take a new value.
  assign en       = !m_valid || m_ready;
  assign s_ready  = en;
  assign accept   = s_valid && en;
  assign is_final = s_last || (bcnt == BCNT_W'(BEATS - 1));

  // Tag for the beat entering the tree
  always_comb begin
    in_tag       = '0;
    in_tag.valid = accept;
    in_tag.fin   = is_final;
    in_tag.bnum  = BNUM_W'(bcnt);
  end

  // Beat position within the current frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= '0;
    end else if (accept) begin
      bcnt <= is_final ? '0 : bcnt + BCNT_W'(1);
    end
  end

  popcnt_tree #(
    .DATA_W (DATA_W)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .data    (s_data),
    .tag_in  (in_tag),
    .tag_out (p2_tag),
    .sum     (p2_sum)
  );

  // Running frame total including the beat now in P2
  always_comb begin
    total  = acc + CNT_W'(p2_sum);
    nbeats = BCNT_W'(p2_tag.bnum) + BCNT_W'(1);
  end

  // P3: accumulate, and load the frame result on the final beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      m_valid <= 1'b0;
      m_ones  <= '0;
      m_beats <= '0;
      m_short <= 1'b0;
    end else if (en) begin
      m_valid <= p2_tag.valid && p2_tag.fin;
      if (p2_tag.valid) begin
        if (p2_tag.fin) begin
          m_ones  <= total;
          m_beats <= nbeats;
          m_short <= nbeats < BCNT_W'(BEATS);
          acc     <= '0;
        end else begin
          acc <= total;
        end
      end
    end
  end

`ifdef POPCNT_THRESH_EN
  // Threshold flag registered alongside m_ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_over <= 1'b0;
    end else if (en && p2_tag.valid && p2_tag.fin) begin
      m_over <= total >= thresh;
    end
  end
`endif

endmodule
